axi_rd_arbiter: RTL and testbench
=================================

Name: axi_rd_arbiter

Overview:
Shares the single AXI read port between the icache (master 0) and the dcache/uncached path (master 1).
- Accepts one AR request at a time by round-robin.
- Forwards it on the slave AR channel and routes the R burst back to the owner until the rlast handshake.
- Sits between the cache AR/R ports and the SoC AXI interconnect. The write channels bypass this block.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
ID_W, 4, AXI ID width; s_arid carries the owner index zero-extended

Ports:
clk  input  1  system clock
cpu_rst_n  input  1  reset, asynchronous, active-low
m0_arvalid / m1_arvalid  input  1  master read request valid
m0_arready / m1_arready  output  1  request accepted (grant)
m0_araddr / m1_araddr  input  ADDR_W  request address
m0_arlen / m1_arlen  input  8  burst length minus one
m0_arsize / m1_arsize  input  3  beat size
m0_arburst / m1_arburst  input  2  burst type
m0_rvalid / m1_rvalid  output  1  read beat valid, owner only
m0_rready / m1_rready  input  1  master ready for a beat
m0_rdata / m1_rdata  output  DATA_W  broadcast of s_rdata
m0_rresp / m1_rresp  output  2  broadcast of s_rresp
m0_rlast / m1_rlast  output  1  broadcast of s_rlast
s_arvalid  output  1  slave request valid (registered)
s_arready  input  1  slave accepted request
s_arid  output  ID_W  owner index
s_araddr  output  ADDR_W  latched address
s_arlen / s_arsize / s_arburst  output  8/3/2  latched burst fields
s_rvalid  input  1  slave beat valid
s_rready  output  1  routed owner rready
s_rdata / s_rresp / s_rlast / s_rid  input  DATA_W/2/1/ID_W  slave R channel

Behaviour:
- Reset (async, cpu_rst_n low):
  - state=IDLE, owner=0, rr_ptr=0 (m0 favoured).
  - s_arvalid=0; all s_ar* fields 0.
  - m*_arready=0, m*_rvalid=0, s_rready=0.
- Reset asserted mid-transaction aborts the transaction. Nothing resumes after release.
- Handshake rules: AXI valid/ready. A master's arvalid, once high, is held with its fields stable until that master's arready.
- State IDLE:
  - If exactly one m*_arvalid is high, that master wins.
  - If both are high, the master selected by rr_ptr wins (rr_ptr=0 -> m0).
  - Winner's arready is high combinationally in the same cycle; the loser's arready stays 0.
  - Latch the winner's addr/len/size/burst into the s_ar* registers. Set owner=winner, s_arid=winner, s_arvalid<=1, go to ADDR.
- State ADDR:
  - Hold s_arvalid and all s_ar* fields stable until s_arready.
  - On s_arvalid&&s_arready: s_arvalid<=0, go to DATA.
  - No master arready is asserted in this state.
- State DATA:
  - m[owner]_rvalid = s_rvalid; the non-owner rvalid is 0.
  - s_rready = m[owner]_rready, combinational.
  - On s_rvalid&&s_rready&&s_rlast: rr_ptr<=~owner, go to IDLE.
  - s_rid is not checked, because only one transaction is ever outstanding.
- Latency:
  - Accept in cycle T; s_arvalid high at T+1.
  - After the rlast handshake at cycle T, the next grant can occur at T+1.
  - So there is a minimum of one idle cycle between bursts on the AR side.
- Width rules: arlen is passed through unmodified; the arbiter does not count beats and relies on s_rlast.
- m*_arready never goes high outside IDLE. Requests arriving in ADDR/DATA wait.
- Fairness: under continuous requests from both masters, grants alternate.

Decomposition:
- Shared package axi_pkg:
  - BURST_INCR=2'b01, SIZE_WORD=3'b010.
  - Arbiter state encoding IDLE/ADDR/DATA.
  - Master index constants MST_ICACHE=0, MST_DCACHE=1.
- One sub-module is natural: rr_arb2, the 2-way round-robin picker.
  - Inputs: req[1:0], ptr. Output: grant one-hot, combinational.

Test Plan:
1. m0 only, araddr=0x1FC00040, arlen=15, s_arready after 2 cycles -> m0_arready in cycle 0; s_arvalid from cycle 1 with s_arid=0 and s_araddr=0x1FC00040; 16 beats reach m0; m1_rvalid stays 0; IDLE after rlast.
2. Both arvalid high in the first cycle after reset -> m0 granted, m1_arready=0 throughout; after m0 rlast, m1 granted in the next cycle with s_arid=1 and its own address.
3. Both masters requesting continuously for 4 bursts -> grant order m0, m1, m0, m1; no beat is delivered to the wrong master.
4. m1 burst with m1_rready low for 3 cycles at beat 5 -> s_rready low for those cycles; 16 beats received with data in order 0..15.
5. s_arready held low 10 cycles -> s_arvalid, s_araddr and s_arlen stable throughout; neither arready rises.
6. cpu_rst_n low during DATA beat 7 -> outputs go to reset values immediately (asynchronously); after release, a new m1 request at 0x80001000 completes normally with s_arid=1.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI read-arbiter definitions: burst/size encodings, FSM states, master indices.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'b010;

  localparam logic MST_ICACHE = 1'b0;
  localparam logic MST_DCACHE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: one-hot grant from a request pair and a priority pointer.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is consumed.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  // A lone request wins outright; a tie goes to the master the pointer names.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read port between icache (m0) and dcache (m1), one burst in flight at a time.
// Latency: grant in the request cycle, s_arvalid the cycle after; next grant one cycle after rlast.
// Backpressure: arready only in IDLE; s_rready follows the owner's rready combinationally.
module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              cpu_rst_n,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [7:0]        m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [7:0]        m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,
  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [ID_W-1:0]   s_arid,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [7:0]        s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast,
  input  logic [ID_W-1:0]   s_rid
);

  arb_state_t state;
  logic       owner;
  logic       rr_ptr;
  logic [1:0] req;
  logic [1:0] grant;
  logic       can_grant;
  logic       in_data;
  logic       unused_rid;

  // Only one burst is ever outstanding, so the returned ID carries no information.
  assign unused_rid = ^s_rid;

  assign req = {m1_arvalid, m0_arvalid};

  rr_arb2 u_rr_arb2 (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // Reset is folded in so a master holding arvalid through reset never sees a grant.
  assign can_grant  = (state == ST_IDLE) && cpu_rst_n;
  assign m0_arready = can_grant && grant[0];
  assign m1_arready = can_grant && grant[1];

  assign in_data   = (state == ST_DATA);
  assign m0_rvalid = in_data && (owner == MST_ICACHE) && s_rvalid;
  assign m1_rvalid = in_data && (owner == MST_DCACHE) && s_rvalid;
  assign s_rready  = in_data && ((owner == MST_DCACHE) ? m1_rready : m0_rready);

  assign m0_rdata = s_rdata;
  assign m0_rresp = s_rresp;
  assign m0_rlast = s_rlast;
  assign m1_rdata = s_rdata;
  assign m1_rresp = s_rresp;
  assign m1_rlast = s_rlast;

  // Arbitration FSM: latch the winner's request, present it to the slave, then follow the burst to rlast.
  always_ff @(posedge clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state     <= ST_IDLE;
      owner     <= MST_ICACHE;
      rr_ptr    <= MST_ICACHE;
      s_arvalid <= 1'b0;
      s_arid    <= '0;
      s_araddr  <= '0;
      s_arlen   <= '0;
      s_arsize  <= '0;
      s_arburst <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            owner     <= grant[1];
            s_arid    <= {{(ID_W-1){1'b0}}, grant[1]};
            s_araddr  <= grant[1] ? m1_araddr  : m0_araddr;
            s_arlen   <= grant[1] ? m1_arlen   : m0_arlen;
            s_arsize  <= grant[1] ? m1_arsize  : m0_arsize;
            s_arburst <= grant[1] ? m1_arburst : m0_arburst;
            s_arvalid <= 1'b1;
            state     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (s_arready) begin
            s_arvalid <= 1'b0;
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (s_rvalid && s_rready && s_rlast) begin
            rr_ptr <= ~owner;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: grant, address hold, burst routing, fairness, reset abort.
// Inputs change on the falling edge; outputs are sampled 1 ns after it.
// The slave side is driven by hand per scenario.
module tb_axi_rd_arbiter;
  import axi_pkg::*;

  logic        clk = 1'b0;
  logic        cpu_rst_n;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
  logic [31:0] m0_araddr, m0_rdata;
  logic [7:0]  m0_arlen;
  logic [2:0]  m0_arsize;
  logic [1:0]  m0_arburst, m0_rresp;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
  logic [31:0] m1_araddr, m1_rdata;
  logic [7:0]  m1_arlen;
  logic [2:0]  m1_arsize;
  logic [1:0]  m1_arburst, m1_rresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [3:0]  s_arid, s_rid;
  logic [31:0] s_araddr, s_rdata;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst, s_rresp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
    .clk(clk), .cpu_rst_n(cpu_rst_n),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
    .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata),
    .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
    .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata),
    .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rid(s_rid)
  );

  task automatic set_arvalid(input logic who, input logic v);
    if (who) m1_arvalid = v; else m0_arvalid = v;
  endtask

  task automatic set_rready(input logic who, input logic v);
    if (who) m1_rready = v; else m0_rready = v;
  endtask

  // Called with the request(s) already driven in the current falling-edge slot.
  task automatic grant_and_addr(input logic who, input logic [31:0] addr,
                                input logic [7:0] len, input int ardly);
    #1;
    checks++;
    if ({m1_arready, m0_arready} !== (who ? 2'b10 : 2'b01)) begin
      errors++;
      $display("FAIL grant: arready{m1,m0}=%b expected %b", {m1_arready, m0_arready}, (who ? 2'b10 : 2'b01));
    end
    @(negedge clk);
    set_arvalid(who, 1'b0);
    #1;
    checks++;
    if ({s_arvalid, s_arid, s_araddr, s_arlen} !== {1'b1, 3'b000, who, addr, len}) begin
      errors++;
      $display("FAIL ar_issue: vld=%b id=%0d addr=%h len=%0d expected vld=1 id=%0d addr=%h len=%0d",
               s_arvalid, s_arid, s_araddr, s_arlen, who, addr, len);
    end
    checks++;
    if ({s_arsize, s_arburst} !== (who ? {3'b011, BURST_INCR} : {SIZE_WORD, BURST_INCR})) begin
      errors++;
      $display("FAIL ar_fields: size=%b burst=%b", s_arsize, s_arburst);
    end
    for (int k = 0; k < ardly; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({s_arvalid, s_araddr, s_arlen, m0_arready, m1_arready} !== {1'b1, addr, len, 2'b00}) begin
        errors++;
        $display("FAIL ar_hold cycle %0d: vld=%b addr=%h len=%0d arready{m0,m1}=%b%b expected vld=1 addr=%h len=%0d arready=00",
                 k, s_arvalid, s_araddr, s_arlen, m0_arready, m1_arready, addr, len);
      end
    end
    s_arready = 1'b1;
    @(negedge clk);
    s_arready = 1'b0;
    #1;
    checks++;
    if (s_arvalid !== 1'b0) begin
      errors++;
      $display("FAIL ar_drop: s_arvalid=%b expected 0", s_arvalid);
    end
  endtask

  // Streams nbeats with data dbase+i; optionally the owner withholds rready at one beat.
  task automatic burst(input logic who, input int nbeats, input logic [31:0] dbase,
                       input int stall_at, input int stall_len);
    logic own_rv, oth_rv;
    for (int i = 0; i < nbeats; i++) begin
      @(negedge clk);
      s_rvalid = 1'b1;
      s_rdata  = dbase + i;
      s_rlast  = (i == nbeats - 1);
      set_rready(who, 1'b1);
      if (i == stall_at) begin
        set_rready(who, 1'b0);
        for (int k = 0; k < stall_len; k++) begin
          #1;
          checks++;
          if (s_rready !== 1'b0) begin
            errors++;
            $display("FAIL stall beat %0d cycle %0d: s_rready=%b expected 0", i, k, s_rready);
          end
          @(negedge clk);
        end
        set_rready(who, 1'b1);
      end
      #1;
      own_rv = who ? m1_rvalid : m0_rvalid;
      oth_rv = who ? m0_rvalid : m1_rvalid;
      checks++;
      if ({own_rv, oth_rv, s_rready, m0_arready, m1_arready} !== 5'b10100) begin
        errors++;
        $display("FAIL beat_route %0d: own_rv=%b other_rv=%b s_rready=%b arready{m0,m1}=%b%b expected 1 0 1 00",
                 i, own_rv, oth_rv, s_rready, m0_arready, m1_arready);
      end
      checks++;
      if ((who ? m1_rdata : m0_rdata) !== dbase + i) begin
        errors++;
        $display("FAIL beat_data %0d: got %h expected %h", i, (who ? m1_rdata : m0_rdata), dbase + i);
      end
    end
    @(negedge clk);
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    #1;
    checks++;
    if (s_rready !== 1'b0) begin
      errors++;
      $display("FAIL back_to_idle: s_rready=%b expected 0 with owner rready still high", s_rready);
    end
    set_rready(who, 1'b0);
  endtask

  task automatic test_reset;
    cpu_rst_n = 1'b0;
    m0_arvalid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_rready, s_arvalid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: arready=%b%b rvalid=%b%b s_rready=%b s_arvalid=%b expected all 0",
               m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_rready, s_arvalid);
    end
    checks++;
    if ({s_arid, s_araddr, s_arlen, s_arsize, s_arburst} !== '0) begin
      errors++;
      $display("FAIL reset_fields: id=%h addr=%h len=%h size=%b burst=%b expected 0",
               s_arid, s_araddr, s_arlen, s_arsize, s_arburst);
    end
    @(negedge clk);
    m0_arvalid = 1'b0;
    cpu_rst_n = 1'b1;
  endtask

  task automatic test_m0_only;
    @(negedge clk);
    m0_arvalid = 1'b1; m0_araddr = 32'h1FC0_0040; m0_arlen = 8'd15;
    grant_and_addr(1'b0, 32'h1FC0_0040, 8'd15, 2);
    burst(1'b0, 16, 32'h0000_0100, -1, 0);
  endtask

  task automatic test_both_after_reset;
    @(negedge clk);
    cpu_rst_n = 1'b0;
    @(negedge clk);
    cpu_rst_n = 1'b1;
    m0_arvalid = 1'b1; m0_araddr = 32'h0000_4000; m0_arlen = 8'd3;
    m1_arvalid = 1'b1; m1_araddr = 32'h0000_8000; m1_arlen = 8'd1;
    grant_and_addr(1'b0, 32'h0000_4000, 8'd3, 0);
    burst(1'b0, 4, 32'h0000_0200, -1, 0);
    grant_and_addr(1'b1, 32'h0000_8000, 8'd1, 0);
    burst(1'b1, 2, 32'h0000_0300, -1, 0);
  endtask

  task automatic test_fairness;
    logic who;
    @(negedge clk);
    m0_arvalid = 1'b1; m0_araddr = 32'h0000_1000; m0_arlen = 8'd3;
    m1_arvalid = 1'b1; m1_araddr = 32'h0000_2000; m1_arlen = 8'd3;
    for (int b = 0; b < 4; b++) begin
      who = b[0];
      grant_and_addr(who, who ? 32'h0000_2000 : 32'h0000_1000, 8'd3, 0);
      if (b < 2) set_arvalid(who, 1'b1);
      burst(who, 4, 32'h0000_1000 * (b + 1), -1, 0);
    end
  endtask

  task automatic test_rready_stall;
    @(negedge clk);
    m1_arvalid = 1'b1; m1_araddr = 32'h0000_3000; m1_arlen = 8'd15;
    grant_and_addr(1'b1, 32'h0000_3000, 8'd15, 0);
    burst(1'b1, 16, 32'h0000_0000, 5, 3);
  endtask

  task automatic test_arready_hold;
    @(negedge clk);
    m0_arvalid = 1'b1; m0_araddr = 32'h0000_5A00; m0_arlen = 8'd7;
    grant_and_addr(1'b0, 32'h0000_5A00, 8'd7, 10);
    burst(1'b0, 8, 32'h0000_0500, -1, 0);
  endtask

  task automatic test_reset_mid_burst;
    @(negedge clk);
    m0_arvalid = 1'b1; m0_araddr = 32'h0000_6000; m0_arlen = 8'd15;
    grant_and_addr(1'b0, 32'h0000_6000, 8'd15, 0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      s_rvalid = 1'b1; s_rdata = i; s_rlast = 1'b0; m0_rready = 1'b1;
    end
    @(negedge clk);
    s_rdata = 32'd7;
    #1;
    checks++;
    if ({m0_rvalid, s_rready} !== 2'b11) begin
      errors++;
      $display("FAIL pre_abort: m0_rvalid=%b s_rready=%b expected 1 1", m0_rvalid, s_rready);
    end
    cpu_rst_n = 1'b0;
    #1;
    checks++;
    if ({m0_rvalid, m1_rvalid, s_rready, s_arvalid, s_arid, s_araddr, s_arlen} !== '0) begin
      errors++;
      $display("FAIL async_abort: rvalid=%b%b s_rready=%b s_arvalid=%b id=%h addr=%h len=%h expected all 0",
               m0_rvalid, m1_rvalid, s_rready, s_arvalid, s_arid, s_araddr, s_arlen);
    end
    @(negedge clk);
    s_rvalid = 1'b0; m0_rready = 1'b0;
    cpu_rst_n = 1'b1;
    @(negedge clk);
    m1_arvalid = 1'b1; m1_araddr = 32'h8000_1000; m1_arlen = 8'd3;
    grant_and_addr(1'b1, 32'h8000_1000, 8'd3, 1);
    burst(1'b1, 4, 32'h0000_00A0, -1, 0);
  endtask

  initial begin
    m0_arvalid = 1'b0; m0_araddr = '0; m0_arlen = '0; m0_arsize = SIZE_WORD; m0_arburst = BURST_INCR; m0_rready = 1'b0;
    m1_arvalid = 1'b0; m1_araddr = '0; m1_arlen = '0; m1_arsize = 3'b011;    m1_arburst = BURST_INCR; m1_rready = 1'b0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00; s_rlast = 1'b0; s_rid = '0;
    cpu_rst_n = 1'b0;
    test_reset;
    test_m0_only;
    test_both_after_reset;
    test_fairness;
    test_rready_stall;
    test_arready_hold;
    test_reset_mid_burst;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
